// File: rtl/core_pkg.sv
// Shared types for the writeback stage: result sources, load funct3 encodings
// and the writeback FSM state.
package core_pkg;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_PC4  = 2'd1,
        SRC_LOAD = 2'd2
    } wb_src_t;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_LOAD   = 2'd1,
        FAULT_PULSE = 2'd2
    } wb_state_t;

    // x0 is hardwired to zero, so a write to it is always squashed.
    function automatic logic rd_writes(input logic rd_write, input logic [4:0] rd_id);
        return rd_write && (rd_id != 5'd0);
    endfunction

endpackage

// File: rtl/core_load_extend.sv
// Selects the addressed byte/halfword of a raw aligned load word and
// sign- or zero-extends it to 32 bits.
module core_load_extend
    import core_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = data[7:0];
        case (addr_lo)
            2'd0: byte_sel = data[7:0];
            2'd1: byte_sel = data[15:8];
            2'd2: byte_sel = data[23:16];
            2'd3: byte_sel = data[31:24];
            default: byte_sel = data[7:0];
        endcase
    end

    assign half_sel = addr_lo[1] ? data[31:16] : data[15:0];

    always_comb begin
        // NOTE: assigning a default before the case keeps this block purely
        // combinational; a path that leaves value unassigned infers a latch.
        value = data;
        case (funct3)
            F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   value = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  value = {24'd0, byte_sel};
            F3_LHU:  value = {16'd0, half_sel};
            default: value = data;  // LW and reserved encodings
        endcase
    end

endmodule

// File: rtl/core_writeback.sv
// Writeback stage: retires ALU/PC+4 results with one cycle of latency and
// tracks a single outstanding load until its response, bus error or timeout.
module core_writeback
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_rd_id,
    input  logic        wb_rd_write,
    input  logic [1:0]  wb_src,
    input  logic [31:0] wb_alu_value,
    input  logic [31:0] wb_pc,
    input  logic [2:0]  wb_load_funct3,
    input  logic [1:0]  wb_addr_lo,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        reg_d_en,
    output logic        reg_d_write,
    output logic [4:0]  reg_d_id,
    output logic [31:0] reg_d_value,
    output logic        load_fault,
    output logic        pend_valid,
    output logic [4:0]  pend_rd_id
);

    localparam int unsigned CNT_W =
        (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    wb_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ld_write_q, ld_write_d;
    logic [2:0]       ld_funct3_q, ld_funct3_d;
    logic [1:0]       ld_addr_lo_q, ld_addr_lo_d;

    logic             en_d, write_d, fault_d, pend_valid_d;
    logic [4:0]       id_d, pend_rd_id_d;
    logic [31:0]      value_d;
    logic [31:0]      load_value;
    logic             rsp_ok, rsp_bad;

    core_load_extend u_load_extend (
        .data    (mem_rsp_data),
        .funct3  (ld_funct3_q),
        .addr_lo (ld_addr_lo_q),
        .value   (load_value)
    );

    assign wb_ready = (state_q == IDLE);
    assign rsp_ok   = mem_rsp_valid && !mem_rsp_err;
    assign rsp_bad  = mem_rsp_valid && mem_rsp_err;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ld_write_d   = ld_write_q;
        ld_funct3_d  = ld_funct3_q;
        ld_addr_lo_d = ld_addr_lo_q;
        en_d         = 1'b0;
        write_d      = 1'b0;
        fault_d      = 1'b0;
        id_d         = reg_d_id;
        value_d      = reg_d_value;
        pend_valid_d = pend_valid;
        pend_rd_id_d = pend_rd_id;

        case (state_q)
            IDLE: begin
                if (wb_valid) begin
                    if (wb_src == SRC_LOAD) begin
                        state_d      = WAIT_LOAD;
                        cnt_d        = '0;
                        ld_write_d   = wb_rd_write;
                        ld_funct3_d  = wb_load_funct3;
                        ld_addr_lo_d = wb_addr_lo;
                        pend_valid_d = 1'b1;
                        pend_rd_id_d = wb_rd_id;
                    end else begin
                        en_d    = 1'b1;
                        write_d = rd_writes(wb_rd_write, wb_rd_id);
                        id_d    = wb_rd_id;
                        // Reserved source encoding 3 falls through to ALU.
                        value_d = (wb_src == SRC_PC4) ? (wb_pc + 32'd4) : wb_alu_value;
                    end
                end
            end
            WAIT_LOAD: begin
                // A clean response wins over a coincident timeout.
                if (rsp_ok) begin
                    state_d      = IDLE;
                    en_d         = 1'b1;
                    write_d      = rd_writes(ld_write_q, pend_rd_id);
                    id_d         = pend_rd_id;
                    value_d      = load_value;
                    pend_valid_d = 1'b0;
                end else if (rsp_bad || (cnt_q == CNT_LIMIT)) begin
                    state_d      = FAULT_PULSE;
                    en_d         = 1'b1;
                    fault_d      = 1'b1;
                    id_d         = pend_rd_id;
                    pend_valid_d = 1'b0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FAULT_PULSE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ld_write_q   <= 1'b0;
            ld_funct3_q  <= 3'd0;
            ld_addr_lo_q <= 2'd0;
            reg_d_en     <= 1'b0;
            reg_d_write  <= 1'b0;
            reg_d_id     <= 5'd0;
            reg_d_value  <= 32'd0;
            load_fault   <= 1'b0;
            pend_valid   <= 1'b0;
            pend_rd_id   <= 5'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ld_write_q   <= ld_write_d;
            ld_funct3_q  <= ld_funct3_d;
            ld_addr_lo_q <= ld_addr_lo_d;
            reg_d_en     <= en_d;
            reg_d_write  <= write_d;
            reg_d_id     <= id_d;
            reg_d_value  <= value_d;
            load_fault   <= fault_d;
            pend_valid   <= pend_valid_d;
            pend_rd_id   <= pend_rd_id_d;
        end
    end

endmodule

// File: tb/tb_core_writeback.sv
// Directed bench for core_writeback: a default-timeout instance for the main
// flow and a TIMEOUT_CYCLES=4 instance for the timeout corner.
module tb_core_writeback;
    import core_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_rd_id;
    logic        wb_rd_write;
    logic [1:0]  wb_src;
    logic [31:0] wb_alu_value;
    logic [31:0] wb_pc;
    logic [2:0]  wb_load_funct3;
    logic [1:0]  wb_addr_lo;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;

    logic        wb_ready,    t4_wb_ready;
    logic        reg_d_en,    t4_reg_d_en;
    logic        reg_d_write, t4_reg_d_write;
    logic [4:0]  reg_d_id,    t4_reg_d_id;
    logic [31:0] reg_d_value, t4_reg_d_value;
    logic        load_fault,  t4_load_fault;
    logic        pend_valid,  t4_pend_valid;
    logic [4:0]  pend_rd_id,  t4_pend_rd_id;

    int n_vec = 0;
    int n_err = 0;

    core_writeback dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd_id(wb_rd_id), .wb_rd_write(wb_rd_write), .wb_src(wb_src),
        .wb_alu_value(wb_alu_value), .wb_pc(wb_pc),
        .wb_load_funct3(wb_load_funct3), .wb_addr_lo(wb_addr_lo),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_err(mem_rsp_err),
        .reg_d_en(reg_d_en), .reg_d_write(reg_d_write),
        .reg_d_id(reg_d_id), .reg_d_value(reg_d_value),
        .load_fault(load_fault), .pend_valid(pend_valid), .pend_rd_id(pend_rd_id)
    );

    core_writeback #(.TIMEOUT_CYCLES(4)) dut_t4 (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_ready(t4_wb_ready),
        .wb_rd_id(wb_rd_id), .wb_rd_write(wb_rd_write), .wb_src(wb_src),
        .wb_alu_value(wb_alu_value), .wb_pc(wb_pc),
        .wb_load_funct3(wb_load_funct3), .wb_addr_lo(wb_addr_lo),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_err(mem_rsp_err),
        .reg_d_en(t4_reg_d_en), .reg_d_write(t4_reg_d_write),
        .reg_d_id(t4_reg_d_id), .reg_d_value(t4_reg_d_value),
        .load_fault(t4_load_fault), .pend_valid(t4_pend_valid),
        .pend_rd_id(t4_pend_rd_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it, away from the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] src, input logic [4:0] rd, input logic wr,
                         input logic [31:0] alu, input logic [31:0] pc,
                         input logic [2:0] f3, input logic [1:0] alo);
        wb_valid       = 1'b1;
        wb_src         = src;
        wb_rd_id       = rd;
        wb_rd_write    = wr;
        wb_alu_value   = alu;
        wb_pc          = pc;
        wb_load_funct3 = f3;
        wb_addr_lo     = alo;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic err);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        mem_rsp_err   = err;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        wb_valid = 1'b0; wb_rd_id = '0; wb_rd_write = 1'b0; wb_src = '0;
        wb_alu_value = '0; wb_pc = '0; wb_load_funct3 = '0; wb_addr_lo = '0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
        step();
        step();

        chk("rst_en",       32'(reg_d_en),    32'd0);
        chk("rst_write",    32'(reg_d_write), 32'd0);
        chk("rst_id",       32'(reg_d_id),    32'd0);
        chk("rst_value",    reg_d_value,      32'd0);
        chk("rst_fault",    32'(load_fault),  32'd0);
        chk("rst_pend",     32'(pend_valid),  32'd0);
        chk("rst_pend_id",  32'(pend_rd_id),  32'd0);
        chk("rst_ready",    32'(wb_ready),    32'd1);
        rst_n = 1'b1;
        step();

        // ALU write to x5
        offer(2'd0, 5'd5, 1'b1, 32'hDEADBEEF, 32'h0, 3'd0, 2'd0);
        chk("alu_en",    32'(reg_d_en),    32'd1);
        chk("alu_write", 32'(reg_d_write), 32'd1);
        chk("alu_id",    32'(reg_d_id),    32'd5);
        chk("alu_value", reg_d_value,      32'hDEADBEEF);
        step();
        chk("alu_en_drop",  32'(reg_d_en), 32'd0);
        chk("alu_val_hold", reg_d_value,   32'hDEADBEEF);

        // PC4 to x0 wraps and is suppressed
        offer(2'd1, 5'd0, 1'b1, 32'h1111_1111, 32'hFFFFFFFC, 3'd0, 2'd0);
        chk("x0_en",    32'(reg_d_en),    32'd1);
        chk("x0_write", 32'(reg_d_write), 32'd0);
        chk("x0_value", reg_d_value,      32'h0000_0000);
        step();

        // PC4 to x7, then reserved source 3 behaves as ALU
        offer(2'd1, 5'd7, 1'b1, 32'h2222_2222, 32'h0000_0100, 3'd0, 2'd0);
        chk("pc4_value", reg_d_value, 32'h0000_0104);
        offer(2'd3, 5'd8, 1'b1, 32'h3333_3333, 32'h0000_0100, 3'd0, 2'd0);
        chk("src3_value", reg_d_value,      32'h3333_3333);
        chk("src3_write", 32'(reg_d_write), 32'd1);
        step();

        // LB addr_lo=3 after 4 wait cycles
        offer(2'd2, 5'd9, 1'b1, 32'h0, 32'h0, F3_LB, 2'd3);
        chk("lb_pend",    32'(pend_valid), 32'd1);
        chk("lb_pend_id", 32'(pend_rd_id), 32'd9);
        for (int i = 0; i < 4; i++) begin
            chk("lb_wait_ready", 32'(wb_ready), 32'd0);
            chk("lb_wait_en",    32'(reg_d_en), 32'd0);
            step();
        end
        chk("lb_wait5_ready", 32'(wb_ready), 32'd0);
        respond(32'h80112233, 1'b0);
        chk("lb_en",     32'(reg_d_en),    32'd1);
        chk("lb_write",  32'(reg_d_write), 32'd1);
        chk("lb_id",     32'(reg_d_id),    32'd9);
        chk("lb_value",  reg_d_value,      32'hFFFFFF80);
        chk("lb_pend_c", 32'(pend_valid),  32'd0);
        chk("lb_ready",  32'(wb_ready),    32'd1);
        step();

        // LHU addr_lo=2 on the same data
        offer(2'd2, 5'd10, 1'b1, 32'h0, 32'h0, F3_LHU, 2'd2);
        for (int i = 0; i < 2; i++) begin
            chk("lhu_wait_ready", 32'(wb_ready), 32'd0);
            step();
        end
        respond(32'h80112233, 1'b0);
        chk("lhu_value", reg_d_value, 32'h00008011);
        step();

        // LH addr_lo=1 uses the low half; reserved funct3=3 decodes as LW
        offer(2'd2, 5'd11, 1'b1, 32'h0, 32'h0, F3_LH, 2'd1);
        respond(32'h8011F233, 1'b0);
        chk("lh_value", reg_d_value, 32'hFFFFF233);
        step();
        offer(2'd2, 5'd12, 1'b0, 32'h0, 32'h0, 3'd3, 2'd3);
        respond(32'h80112233, 1'b0);
        chk("f3res_value", reg_d_value,      32'h80112233);
        chk("f3res_write", 32'(reg_d_write), 32'd0);
        step();

        // Stray response while idle
        respond(32'hCAFE_F00D, 1'b0);
        chk("stray_idle_en",  32'(reg_d_en),  32'd0);
        chk("stray_idle_val", reg_d_value,    32'h80112233);

        // Bus error on LW
        offer(2'd2, 5'd13, 1'b1, 32'h0, 32'h0, F3_LW, 2'd0);
        step();
        respond(32'h5555_5555, 1'b1);
        chk("err_fault", 32'(load_fault),  32'd1);
        chk("err_en",    32'(reg_d_en),    32'd1);
        chk("err_write", 32'(reg_d_write), 32'd0);
        chk("err_pend",  32'(pend_valid),  32'd0);
        chk("err_ready", 32'(wb_ready),    32'd0);
        step();
        chk("err_fault_drop", 32'(load_fault), 32'd0);
        chk("err_en_drop",    32'(reg_d_en),   32'd0);
        chk("err_ready_back", 32'(wb_ready),   32'd1);

        // Timeout on the TIMEOUT_CYCLES=4 instance
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        offer(2'd2, 5'd14, 1'b1, 32'h0, 32'h0, F3_LW, 2'd0);
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_fault", 32'(t4_load_fault), 32'd0);
            step();
        end
        chk("to_c5_ready", 32'(t4_wb_ready), 32'd0);
        step();
        chk("to_fault",     32'(t4_load_fault),  32'd1);
        chk("to_en",        32'(t4_reg_d_en),    32'd1);
        chk("to_write",     32'(t4_reg_d_write), 32'd0);
        chk("to_pend",      32'(t4_pend_valid),  32'd0);
        chk("dflt_nofault", 32'(load_fault),     32'd0);
        chk("dflt_pend",    32'(pend_valid),     32'd1);
        step();
        chk("to_fault_drop", 32'(t4_load_fault), 32'd0);
        chk("to_ready_back", 32'(t4_wb_ready),   32'd1);
        respond(32'h0, 1'b0);
        step();

        // Response on the timeout cycle wins
        offer(2'd2, 5'd15, 1'b1, 32'h0, 32'h0, F3_LW, 2'd0);
        for (int i = 0; i < 4; i++) step();
        respond(32'h0BADF00D, 1'b0);
        chk("race_en",    32'(t4_reg_d_en),    32'd1);
        chk("race_write", 32'(t4_reg_d_write), 32'd1);
        chk("race_value", t4_reg_d_value,      32'h0BADF00D);
        chk("race_fault", 32'(t4_load_fault),  32'd0);
        step();
        chk("race_no_late_fault", 32'(t4_load_fault), 32'd0);

        // Reset mid-load, then a stray response
        offer(2'd2, 5'd16, 1'b1, 32'h0, 32'h0, F3_LW, 2'd0);
        step();
        chk("mid_pend_before", 32'(pend_valid), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        respond(32'h1234_5678, 1'b0);
        chk("mid_en",    32'(reg_d_en),   32'd0);
        chk("mid_pend",  32'(pend_valid), 32'd0);
        chk("mid_ready", 32'(wb_ready),   32'd1);
        chk("mid_value", reg_d_value,     32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
